// File: rtl/aes_mode_ctrl.sv
// Block-mode sequencer around the AES core: key expansion handshake, ECB/CBC chaining, streaming ports.
// Optional CTR mode is enabled by defining AES_MODE_CTR_EN.
module aes_mode_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [255:0]     cfg_key,
    input  logic             cfg_keylen,
    input  logic             cfg_encdec,
    input  logic [1:0]       cfg_mode,
    input  logic [127:0]     cfg_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             aes_init,
    output logic             aes_next,
    output logic             aes_encdec,
    output logic             aes_keylen,
    output logic [255:0]     aes_key,
    output logic [127:0]     aes_block,
    input  logic             aes_ready,
    input  logic             aes_result_valid,
    input  logic [127:0]     aes_result,
    output logic             busy,
    output logic             key_ok,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [2:0] {
        IDLE, KINIT, KWAIT, READY, ISSUE, ARM, WAIT, OUT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]   mode_r;
    logic         arm_key;
    logic [127:0] chain, chain_nxt;
    logic [127:0] inb;
    logic [127:0] block_nxt, result_nxt;
    logic         is_cbc, is_ctr;
    logic         accept_start, in_fire, core_done;

    assign is_cbc = (mode_r == 2'b01);
`ifdef AES_MODE_CTR_EN
    assign is_ctr = (mode_r == 2'b10);
`else
    assign is_ctr = 1'b0;
`endif

    // A new configuration is only taken between blocks; it also wins over a pending input block.
    assign accept_start = cfg_start && ((state == IDLE) || (state == READY));
    assign in_ready     = (state == READY) && key_ok && !cfg_start;
    assign in_fire      = in_ready && in_valid;
    assign core_done    = (state == WAIT) && aes_ready;

    assign aes_init  = (state == KINIT);
    assign aes_next  = (state == ISSUE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE) && (state != READY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start) state_nxt = KINIT;
            KINIT:   state_nxt = ARM;
            ARM:     state_nxt = arm_key ? KWAIT : WAIT;
            KWAIT:   if (aes_ready) state_nxt = READY;
            READY: begin
                if (cfg_start)    state_nxt = KINIT;
                else if (in_fire) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = ARM;
            WAIT:    if (aes_ready) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = READY;
            default: state_nxt = IDLE;
        endcase
    end

    // Mode-dependent block presented to the core and result/chain update on completion.
    always_comb begin
        block_nxt  = in_data;
        result_nxt = aes_result;
        chain_nxt  = chain;
        if (is_cbc) begin
            if (aes_encdec) begin
                block_nxt = in_data ^ chain;
                chain_nxt = aes_result;
            end else begin
                result_nxt = aes_result ^ chain;
                chain_nxt  = inb;
            end
        end
`ifdef AES_MODE_CTR_EN
        if (is_ctr) begin
            block_nxt  = chain;
            result_nxt = aes_result ^ inb;
            chain_nxt  = chain + 128'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            arm_key    <= 1'b0;
            mode_r     <= 2'b00;
            aes_encdec <= 1'b0;
            aes_keylen <= 1'b0;
            aes_key    <= '0;
            chain      <= '0;
            inb        <= '0;
            aes_block  <= '0;
            out_data   <= '0;
            key_ok     <= 1'b0;
            blk_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                aes_key    <= cfg_key;
                aes_keylen <= cfg_keylen;
                mode_r     <= cfg_mode;
`ifdef AES_MODE_CTR_EN
                aes_encdec <= (cfg_mode == 2'b10) ? 1'b1 : cfg_encdec;
`else
                aes_encdec <= cfg_encdec;
`endif
                chain      <= cfg_iv;
                key_ok     <= 1'b0;
                blk_cnt    <= '0;
            end
            // ARM is shared by key expansion and block issue; this flag picks its successor.
            if (state == KINIT) arm_key <= 1'b1;
            if (state == ISSUE) arm_key <= 1'b0;
            if ((state == KWAIT) && aes_ready) key_ok <= 1'b1;
            if (in_fire) begin
                inb       <= in_data;
                aes_block <= block_nxt;
            end
            if (core_done) begin
                if (aes_result_valid) begin
                    out_data <= result_nxt;
                    chain    <= chain_nxt;
                    blk_cnt  <= blk_cnt + CNT_W'(1);
                end else begin
                    out_data <= '0;
                end
            end
        end
    end

endmodule
